tdm_demux_1x8: RTL and testbench
================================

TDM_DEMUX_1X8 -- requirements
Module: tdm_demux_1x8

Interface
REQ-001 SHALL have port clk, input, 1 bit, sole clock; all logic on rising edge.
REQ-002 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-003 SHALL have port din, input, 1 bit, serial TDM data bit for the current slot.
REQ-004 SHALL have port din_valid, input, 1 bit, din qualifier; one slot consumed per cycle with din_valid=1.
REQ-005 SHALL have port sync, input, 1 bit, frame-start marker; meaningful only with din_valid=1; marks the bit as slot 0.
REQ-006 SHALL have port y, output, 8 bits, last complete frame; slot k lands in y[k].
REQ-007 SHALL have port frame_valid, output, 1 bit, one-cycle pulse when y updates.
REQ-008 SHALL have port sel, output, 4 bits, slot index expected for the next valid bit.
REQ-009 SHALL have port locked, output, 1 bit, high in RUN state.
REQ-010 SHALL have port sync_err, output, 1 bit, one-cycle pulse on misplaced sync.
REQ-011 SHALL have port parity_err, output, 1 bit, one-cycle pulse on parity mismatch (see Configuration).

Function
REQ-012 SHALL implement two states: HUNT (unaligned) and RUN (aligned); locked=1 only in RUN.
REQ-013 HUNT: valid bit without sync SHALL be discarded; sel stays 0.
REQ-014 HUNT: valid bit with sync SHALL be stored as slot 0, sel<=1, next state RUN.
REQ-015 RUN: valid bit without sync SHALL be stored in shadow[sel], sel<=sel+1.
REQ-016 RUN: on the last slot (sel=7, or sel=8 with parity), sel SHALL wrap to 0 and y SHALL load the 8 data bits (shadow plus the current bit if it is a data bit) in the same edge; frame_valid=1 the following cycle only (1-cycle latency from last bit to y).
REQ-017 RUN: valid bit with sync and sel=0 SHALL be treated as a normal slot 0; no error.
REQ-018 RUN: valid bit with sync and sel!=0 SHALL pulse sync_err, discard the partial frame (y unchanged, no frame_valid), store the bit as slot 0, sel<=1; stay in RUN.
REQ-019 Cycles with din_valid=0 SHALL hold all state; din and sync ignored.
REQ-020 y SHALL hold its value between frames; shadow bits SHALL not be visible on y before frame completion.
REQ-021 frame_valid, sync_err and parity_err SHALL be registered outputs, never asserted in the same cycle as reset.

Reset
REQ-022 On rst=1 at a clock edge: state<=HUNT, sel<=0, y<=8'h00, shadow<=0, frame_valid<=0, sync_err<=0, parity_err<=0, locked<=0.
REQ-023 rst SHALL take priority over din_valid/sync; a frame in progress is discarded and no pulses are produced.
REQ-024 The first valid bit after rst deasserts SHALL be processed per HUNT rules.

Configuration
REQ-025 Macro DEMUX_PARITY_EN SHALL select frame length.
REQ-026 With DEMUX_PARITY_EN defined: frame is 9 slots; slot 8 carries even parity over y[7:0]; on slot 8, y loads data and frame_valid pulses; parity_err pulses in the same cycle as frame_valid if XOR(data, parity bit)=1; y still updates.
REQ-027 Without DEMUX_PARITY_EN: frame is 8 slots; sel wraps 7->0; parity_err tied 0; port list unchanged.

Verification
REQ-028 Reset, then sync+valid with bits slot0..7 = 0,1,1,1,0,0,0,1 on consecutive cycles -> y=8'b10001110, frame_valid single pulse one cycle after slot 7, locked=1.
REQ-029 Valid bits with sync=0 after reset -> locked=0, sel=0, y=8'h00, no frame_valid.
REQ-030 In RUN, sync asserted at sel=3 -> sync_err pulse, y unchanged, sel=1 next cycle; following 7 bits complete a frame normally.
REQ-031 Frame 8'hA5 with din_valid deasserted 2 cycles between slots 2 and 3 -> y=8'hA5, frame_valid delayed by 2 cycles, no error.
REQ-032 rst asserted at sel=5 mid-frame -> next cycle sel=0, locked=0, y=8'h00, no frame_valid/sync_err.
REQ-033 DEMUX_PARITY_EN build: frame 8'h0F with parity 0 -> frame_valid, parity_err=0; frame 8'h07 with parity 0 -> frame_valid and parity_err pulse together, y=8'h07.

Source files
------------

// File: rtl/tdm_demux_1x8.sv
// 1-to-8 TDM serial demultiplexer with sync-driven frame alignment.
// Define DEMUX_PARITY_EN for a 9-slot frame whose last slot is an even-parity bit.
module tdm_demux_1x8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_valid,
  input  logic       sync,
  output logic [7:0] y,
  output logic       frame_valid,
  output logic [3:0] sel,
  output logic       locked,
  output logic       sync_err,
  output logic       parity_err
);

`ifdef DEMUX_PARITY_EN
  localparam logic [3:0] LAST_SLOT = 4'd8;

  function automatic logic even_parity(input logic [7:0] v);
    return ^v;
  endfunction
`else
  localparam logic [3:0] LAST_SLOT = 4'd7;
`endif

  typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [3:0] sel_q, sel_d;
  logic [7:0] shadow_q, shadow_d;
  logic [7:0] y_q, y_d;
  logic       frame_valid_q, frame_valid_d;
  logic       sync_err_q, sync_err_d;
  logic       parity_err_q, parity_err_d;
  logic       locked_q, locked_d;
  logic [7:0] frame_s;

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    shadow_d      = shadow_q;
    y_d           = y_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    parity_err_d  = 1'b0;
    frame_s       = shadow_q;
    frame_s[7]    = din;
    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (sync) begin
            shadow_d = {7'd0, din};
            sel_d    = 4'd1;
            state_d  = RUN;
          end else begin
            sel_d = 4'd0;
          end
        end
        RUN: begin
          if (sync && (sel_q != 4'd0)) begin
            // Misplaced sync realigns: the partial frame is dropped.
            sync_err_d = 1'b1;
            shadow_d   = {7'd0, din};
            sel_d      = 4'd1;
          end else if (sel_q == LAST_SLOT) begin
            sel_d         = 4'd0;
            frame_valid_d = 1'b1;
`ifdef DEMUX_PARITY_EN
            y_d          = shadow_q;
            parity_err_d = even_parity(shadow_q) ^ din;
`else
            y_d = frame_s;
`endif
          end else begin
            shadow_d[sel_q[2:0]] = din;
            sel_d                = sel_q + 4'd1;
          end
        end
        default: begin
          state_d = HUNT;
          sel_d   = 4'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    locked_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HUNT;
      sel_q         <= 4'd0;
      shadow_q      <= 8'h00;
      y_q           <= 8'h00;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      parity_err_q  <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      shadow_q      <= shadow_d;
      y_q           <= y_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
      parity_err_q  <= parity_err_d;
      locked_q      <= locked_d;
    end
  end

  assign y           = y_q;
  assign frame_valid = frame_valid_q;
  assign sel         = sel_q;
  assign locked      = locked_q;
  assign sync_err    = sync_err_q;
  assign parity_err  = parity_err_q;

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// Scoreboard bench for tdm_demux_1x8: expected frames are queued as their last slot
// is driven and popped when frame_valid is seen. Honours DEMUX_PARITY_EN.
module tb_tdm_demux_1x8;

`ifdef DEMUX_PARITY_EN
  localparam int NS = 9;
`else
  localparam int NS = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       sync = 1'b0;
  logic [7:0] y;
  logic       frame_valid;
  logic [3:0] sel;
  logic       locked;
  logic       sync_err;
  logic       parity_err;

  typedef struct {
    logic [7:0] y;
    logic       perr;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  tdm_demux_1x8 dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .sync       (sync),
    .y          (y),
    .frame_valid(frame_valid),
    .sel        (sel),
    .locked     (locked),
    .sync_err   (sync_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; afterwards pops the scoreboard on frame_valid and checks sync_err.
  task automatic drive(input logic v, input logic d, input logic s, input logic exp_serr);
    exp_t e;
    din_valid = v;
    din       = d;
    sync      = s;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din       = 1'b0;
    sync      = 1'b0;
    checks++;
    if (sync_err !== exp_serr) begin
      errors++;
      $display("FAIL sync_err: got %b expected %b", sync_err, exp_serr);
    end
    if (frame_valid === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_frame: got frame_valid=1 y=%h, expected no frame", y);
      end else begin
        e = sbq.pop_front();
        if (y !== e.y || parity_err !== e.perr) begin
          errors++;
          $display("FAIL sb_frame: got y=%h perr=%b expected y=%h perr=%b", y, parity_err, e.y, e.perr);
        end
      end
    end else if (parity_err !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL parity_err_alone: got %b expected 0", parity_err);
    end
  endtask

  // Drives slots [first, last_excl) of a frame; sync accompanies slot 0.
  task automatic send_frame(input logic [7:0] data, input logic pbit, input int first, input int last_excl);
    exp_t       e;
    logic [3:0] ki;
    logic       b;
    for (int k = first; k < last_excl; k++) begin
      ki = 4'(k);
      b  = (ki < 4'd8) ? data[ki[2:0]] : pbit;
      if (k == NS - 1) begin
        e.y = data;
`ifdef DEMUX_PARITY_EN
        e.perr = (^data) ^ pbit;
`else
        e.perr = 1'b0;
`endif
        sbq.push_back(e);
      end
      drive(1'b1, b, (k == 0), 1'b0);
    end
  endtask

  task automatic check_sb_empty(input string name);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_frame: got %0d frames outstanding, expected 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    checks++;
    if (y !== 8'h00 || sel !== 4'd0 || locked !== 1'b0 || frame_valid !== 1'b0 || parity_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got y=%h sel=%0d locked=%b fv=%b perr=%b expected 00/0/0/0/0",
               y, sel, locked, frame_valid, parity_err);
    end
  endtask

  task automatic test_hunt;
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (locked !== 1'b0 || sel !== 4'd0 || y !== 8'h00) begin
      errors++;
      $display("FAIL hunt_discard: got locked=%b sel=%0d y=%h expected 0/0/00", locked, sel, y);
    end
    check_sb_empty("hunt");
  endtask

  task automatic test_basic_frame;
    send_frame(8'b10001110, ^(8'b10001110), 0, 4);
    checks++;
    if (y !== 8'h00 || locked !== 1'b1 || sel !== 4'd4) begin
      errors++;
      $display("FAIL basic_mid: got y=%h locked=%b sel=%0d expected 00/1/4", y, locked, sel);
    end
    send_frame(8'b10001110, ^(8'b10001110), 4, NS);
    checks++;
    if (y !== 8'h8E || locked !== 1'b1 || sel !== 4'd0) begin
      errors++;
      $display("FAIL basic_done: got y=%h locked=%b sel=%0d expected 8e/1/0", y, locked, sel);
    end
    check_sb_empty("basic");
  endtask

  task automatic test_back_to_back;
    logic [7:0] d;
    for (int f = 0; f < 4; f++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(d, ^d, 0, NS);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (locked !== 1'b1 || sel !== 4'd0) begin
      errors++;
      $display("FAIL b2b_state: got locked=%b sel=%0d expected 1/0", locked, sel);
    end
    check_sb_empty("b2b");
  endtask

  task automatic test_sync_err;
    logic [7:0] prev;
    prev = y;
    send_frame(8'hFF, 1'b0, 0, 3);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (y !== prev || sel !== 4'd1 || locked !== 1'b1 || frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL sync_err_state: got y=%h sel=%0d locked=%b fv=%b expected %h/1/1/0",
               y, sel, locked, frame_valid, prev);
    end
    send_frame(8'h5B, ^(8'h5B), 1, NS);
    check_sb_empty("sync_err");
  endtask

  task automatic test_gaps;
    send_frame(8'hA5, ^(8'hA5), 0, 3);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (sel !== 4'd3 || locked !== 1'b1) begin
      errors++;
      $display("FAIL gap_hold: got sel=%0d locked=%b expected 3/1", sel, locked);
    end
    send_frame(8'hA5, ^(8'hA5), 3, NS);
    checks++;
    if (y !== 8'hA5) begin
      errors++;
      $display("FAIL gap_y: got %h expected a5", y);
    end
    check_sb_empty("gaps");
  endtask

  task automatic test_reset_mid;
    send_frame(8'h3C, ^(8'h3C), 0, 5);
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    checks++;
    if (sel !== 4'd0 || locked !== 1'b0 || y !== 8'h00 || frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got sel=%0d locked=%b y=%h fv=%b expected 0/0/00/0", sel, locked, y, frame_valid);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (locked !== 1'b0 || sel !== 4'd0) begin
      errors++;
      $display("FAIL post_reset_hunt: got locked=%b sel=%0d expected 0/0", locked, sel);
    end
    send_frame(8'hC3, ^(8'hC3), 0, NS);
    check_sb_empty("reset_mid");
  endtask

`ifdef DEMUX_PARITY_EN
  task automatic test_parity;
    send_frame(8'h0F, 1'b0, 0, NS);
    send_frame(8'h07, 1'b0, 0, NS);
    check_sb_empty("parity");
  endtask
`endif

  initial begin
    test_reset();
    test_hunt();
    test_basic_frame();
    test_back_to_back();
    test_sync_err();
    test_gaps();
    test_reset_mid();
`ifdef DEMUX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
